// File: rtl/blinky_pkg.sv
// Shared constants for the ULX3S blinky: button/LED counts, button roles,
// the knight-rider direction type and the one-hot helper.
package blinky_pkg;

    localparam int NUM_BTN = 7;
    localparam int NUM_LED = 8;
    localparam int POS_W   = $clog2(NUM_LED);

    localparam int BTN_FREEZE = 0;
    localparam int BTN_ALLON  = 1;
    localparam int BTN_ALLOFF = 2;
    localparam int BTN_KNIGHT = 3;
    localparam int BTN_INVERT = 4;
    localparam int BTN_FAST   = 5;
    localparam int BTN_CLEAR  = 6;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    function automatic logic [NUM_LED-1:0] onehot(input logic [POS_W-1:0] pos);
        return NUM_LED'(1) << pos;
    endfunction

endpackage

// File: rtl/blinky_if.sv
// Board-facing bundle of the blinky: raw buttons in, LEDs and the ESP32
// strap pin out.
interface blinky_if;
    import blinky_pkg::*;

    logic [NUM_BTN-1:0] btn;
    logic [NUM_LED-1:0] led;
    logic               wifi_gpio0;

    modport slave  (input  btn, output led, output wifi_gpio0);
    modport master (output btn, input  led, input  wifi_gpio0);

endinterface

// File: rtl/blinky_top_btn_debounce.sv
// One push-button channel: two-flop synchroniser followed by a counter that
// accepts a new level only after it has persisted for 2**DEBOUNCE_W cycles.
module btn_debounce #(
    parameter int DEBOUNCE_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_db
);

    logic                r_sync1;
    logic                r_sync2;
    logic                r_db;
    logic [DEBOUNCE_W:0] r_cnt;

    // The extra MSB flags that 2**DEBOUNCE_W mismatch cycles have been seen;
    // the level is adopted on the following cycle if it still differs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_db) begin
                if (r_cnt[DEBOUNCE_W]) begin
                    r_db  <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + (DEBOUNCE_W + 1)'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_db = r_db;

endmodule

// File: rtl/blinky_top.sv
// ULX3S blinky top: debounced buttons steer a prescaler-driven LED display
// (binary count, knight-rider walk, all-on/off, invert, fast, freeze, clear).
module blinky_top
    import blinky_pkg::*;
#(
    parameter int CNT_W      = 28,
    parameter int DEBOUNCE_W = 16
) (
    input  logic     clk_25mhz,
    input  logic     rst,
    blinky_if.slave  io
);

    logic [NUM_BTN-1:0] w_db;
    logic [CNT_W-1:0]   r_cnt;
    logic [POS_W-1:0]   r_pos;
    logic [POS_W-1:0]   w_pos_next;
    dir_e               r_dir;
    dir_e               w_dir_next;
    logic [NUM_LED-1:0] w_pattern;
    logic [NUM_LED-1:0] w_led_next;
    logic [NUM_LED-1:0] r_led;
    logic               w_freeze;
    logic               w_clear;
    logic               w_fast;
    logic               w_tick;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
        btn_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) u_db (
            .clk   (clk_25mhz),
            .rst   (rst),
            .i_btn (io.btn[g]),
            .o_db  (w_db[g])
        );
    end

    assign w_freeze = w_db[BTN_FREEZE];
    assign w_clear  = w_db[BTN_CLEAR];
    assign w_fast   = w_db[BTN_FAST];
    assign w_tick   = (w_fast ? (&r_cnt[CNT_W-9:0]) : (&r_cnt[CNT_W-7:0]))
                      && !w_freeze && !w_clear;

    // Clear takes priority over freeze.
    always_ff @(posedge clk_25mhz) begin
        if (rst || w_clear) begin
            r_cnt <= '0;
        end else if (!w_freeze) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            r_pos <= '0;
            r_dir <= DIR_UP;
        end else begin
            r_pos <= w_pos_next;
            r_dir <= w_dir_next;
        end
    end

    // Bounce between the end LEDs without dwelling twice on an end value.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        w_pos_next = r_pos;
        w_dir_next = r_dir;
        if (w_tick) begin
            case (r_dir)
                DIR_UP: begin
                    if (r_pos == POS_W'(NUM_LED - 1)) begin
                        w_dir_next = DIR_DOWN;
                        w_pos_next = r_pos - POS_W'(1);
                    end else begin
                        w_pos_next = r_pos + POS_W'(1);
                    end
                end
                DIR_DOWN: begin
                    if (r_pos == '0) begin
                        w_dir_next = DIR_UP;
                        w_pos_next = POS_W'(1);
                    end else begin
                        w_pos_next = r_pos - POS_W'(1);
                    end
                end
                default: begin
                    w_dir_next = DIR_UP;
                    w_pos_next = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_pattern = w_fast ? r_cnt[CNT_W-3 -: NUM_LED] : r_cnt[CNT_W-1 -: NUM_LED];
        if (w_db[BTN_ALLON]) begin
            w_pattern = '1;
        end else if (w_db[BTN_ALLOFF]) begin
            w_pattern = '0;
        end else if (w_db[BTN_KNIGHT]) begin
            w_pattern = onehot(r_pos);
        end
        w_led_next = w_db[BTN_INVERT] ? ~w_pattern : w_pattern;
    end

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            r_led <= '0;
        end else begin
            r_led <= w_led_next;
        end
    end

    assign io.led        = r_led;
    assign io.wifi_gpio0 = 1'b1;

endmodule

// File: tb/tb_blinky_top.sv
// Self-checking bench for blinky_top with a small prescaler and debounce;
// a cycle-level behavioural model predicts every LED value.
module tb_blinky_top;

    localparam int CW = 12;
    localparam int DW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    blinky_if bif ();

    blinky_top #(.CNT_W(CW), .DEBOUNCE_W(DW)) dut (
        .clk_25mhz (clk),
        .rst       (rst),
        .io        (bif)
    );

    always #20 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: counter as an integer, knight position as a 14-step
    // bounce index, debounce as a per-button run length of disagreement.
    int         m_cnt;
    int         m_k;
    int         m_run [7];
    logic [6:0] m_s1, m_s2, m_db;
    logic [7:0] m_led;

    function automatic logic [7:0] model_pattern();
        int         pos;
        logic [7:0] p;
        pos = (m_k <= 7) ? m_k : 14 - m_k;
        if (m_db[1])      p = 8'hFF;
        else if (m_db[2]) p = 8'h00;
        else if (m_db[3]) p = 8'(1 << pos);
        else if (m_db[5]) p = 8'((m_cnt >> 2) & 255);
        else              p = 8'((m_cnt >> 4) & 255);
        return m_db[4] ? ~p : p;
    endfunction

    task automatic model_step();
        bit tick;
        if (rst) begin
            m_cnt = 0; m_k = 0; m_led = 8'h00;
            m_s1 = '0; m_s2 = '0; m_db = '0;
            for (int i = 0; i < 7; i++) m_run[i] = 0;
        end else begin
            tick = (m_db[5] ? ((m_cnt % 16) == 15) : ((m_cnt % 64) == 63))
                   && !m_db[0] && !m_db[6];
            m_led = model_pattern();
            if (tick) m_k = (m_k + 1) % 14;
            if (m_db[6])       m_cnt = 0;
            else if (!m_db[0]) m_cnt = (m_cnt + 1) % (1 << CW);
            for (int i = 0; i < 7; i++) begin
                if (m_s2[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] > (1 << DW)) begin
                        m_db[i]  = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = bif.btn;
        end
    endtask

    // One clock: model follows the edge, outputs are sampled on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bif.btn = '0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            n_checks++;
            if (bif.led !== 8'h00 || bif.wifi_gpio0 !== 1'b1) begin
                n_errors++;
                $display("FAIL reset_hold cyc %0d: led=%h wifi=%b, need led=00 wifi=1", c, bif.led, bif.wifi_gpio0);
            end
        end
        rst = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            cycle();
            n_checks++;
            if (bif.led !== m_led || bif.wifi_gpio0 !== 1'b1) begin
                n_errors++;
                $display("FAIL reset_release cyc %0d: led=%h wifi=%b, need led=%h wifi=1", c, bif.led, bif.wifi_gpio0, m_led);
            end
        end
        n_checks++;
        if (bif.led !== 8'h01) begin
            n_errors++;
            $display("FAIL first_binary_step: led=%h, need 01", bif.led);
        end
    endtask

    task automatic test_allon();
        bif.btn = 7'b0000010;
        for (int c = 0; c < 3; c++) cycle();
        bif.btn = '0;
        for (int c = 0; c < 12; c++) begin
            cycle();
            n_checks++;
            if (bif.led === 8'hFF || bif.led !== m_led) begin
                n_errors++;
                $display("FAIL short_pulse cyc %0d: led=%h, need %h (not FF)", c, bif.led, m_led);
            end
        end
        bif.btn = 7'b0000010;
        for (int c = 1; c <= 8; c++) begin
            cycle();
            n_checks++;
            if (bif.led !== m_led || (c == 7 && bif.led === 8'hFF) || (c == 8 && bif.led !== 8'hFF)) begin
                n_errors++;
                $display("FAIL allon_latency cyc %0d: led=%h, need %h", c, bif.led, (c == 8) ? 8'hFF : m_led);
            end
        end
        bif.btn = '0;
        for (int c = 0; c < 30; c++) begin
            cycle();
            n_checks++;
            if (bif.led !== m_led) begin
                n_errors++;
                $display("FAIL allon_release cyc %0d: led=%h, need %h", c, bif.led, m_led);
            end
        end
    endtask

    task automatic test_knight();
        bif.btn = 7'b0001000;
        for (int c = 0; c < 64 * 16; c++) begin
            cycle();
            n_checks++;
            if (bif.led !== m_led || (c >= 8 && $countones(bif.led) != 1)) begin
                n_errors++;
                $display("FAIL knight_slow cyc %0d: led=%h, need one-hot %h", c, bif.led, m_led);
            end
        end
        bif.btn = 7'b0101000;
        for (int c = 0; c < 16 * 16; c++) begin
            cycle();
            n_checks++;
            if (bif.led !== m_led || $countones(bif.led) != 1) begin
                n_errors++;
                $display("FAIL knight_fast cyc %0d: led=%h, need one-hot %h", c, bif.led, m_led);
            end
        end
    endtask

    task automatic test_freeze_clear();
        logic [7:0] frozen;
        bif.btn = 7'b0000001;
        for (int c = 0; c < 10; c++) cycle();
        frozen = m_led;
        for (int c = 0; c < 1000; c++) begin
            cycle();
            n_checks++;
            if (bif.led !== frozen || bif.led !== m_led) begin
                n_errors++;
                $display("FAIL freeze cyc %0d: led=%h, need constant %h", c, bif.led, frozen);
            end
        end
        bif.btn = 7'b1000000;
        for (int c = 0; c < 10; c++) cycle();
        for (int c = 0; c < 100; c++) begin
            cycle();
            n_checks++;
            if (bif.led !== 8'h00 || bif.led !== m_led) begin
                n_errors++;
                $display("FAIL clear cyc %0d: led=%h, need 00", c, bif.led);
            end
        end
    endtask

    task automatic test_invert_all();
        bif.btn = 7'b0010000;
        for (int c = 0; c < 200; c++) begin
            cycle();
            n_checks++;
            if (bif.led !== m_led) begin
                n_errors++;
                $display("FAIL invert cyc %0d: led=%h, need %h", c, bif.led, m_led);
            end
        end
        bif.btn = 7'h7F;
        for (int c = 0; c < 10; c++) cycle();
        for (int c = 0; c < 50; c++) begin
            cycle();
            n_checks++;
            if (bif.led !== 8'h00) begin
                n_errors++;
                $display("FAIL all_buttons cyc %0d: led=%h, need 00", c, bif.led);
            end
        end
        bif.btn = '0;
        for (int c = 0; c < 100; c++) begin
            cycle();
            n_checks++;
            if (bif.led !== m_led) begin
                n_errors++;
                $display("FAIL resume_binary cyc %0d: led=%h, need %h", c, bif.led, m_led);
            end
        end
    endtask

    task automatic test_random();
        int hold;
        for (int s = 0; s < 60; s++) begin
            bif.btn = 7'($urandom & 32'h7F);
            hold = $urandom_range(1, 14);
            for (int c = 0; c < hold; c++) begin
                cycle();
                n_checks++;
                if (bif.led !== m_led || bif.wifi_gpio0 !== 1'b1) begin
                    n_errors++;
                    $display("FAIL random seg %0d btn=%b: led=%h wifi=%b, need led=%h wifi=1", s, bif.btn, bif.led, bif.wifi_gpio0, m_led);
                end
            end
        end
        bif.btn = '0;
        for (int c = 0; c < 10; c++) cycle();
    endtask

    task automatic test_reset_mid_knight();
        bif.btn = 7'b0001000;
        for (int c = 0; c < 200 + int'($urandom_range(0, 300)); c++) cycle();
        rst = 1'b1;
        cycle();
        n_checks++;
        if (bif.led !== 8'h00 || bif.led !== m_led || bif.wifi_gpio0 !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_reset: led=%h wifi=%b, need led=00 wifi=1", bif.led, bif.wifi_gpio0);
        end
        rst = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            cycle();
            n_checks++;
            if (bif.led !== m_led) begin
                n_errors++;
                $display("FAIL post_reset cyc %0d: led=%h, need %h", c, bif.led, m_led);
            end
        end
        n_checks++;
        if (bif.led !== 8'h01) begin
            n_errors++;
            $display("FAIL knight_pos_after_reset: led=%h, need 01", bif.led);
        end
    endtask

    initial begin
        bif.btn = '0;
        test_reset();
        test_allon();
        test_knight();
        test_freeze_clear();
        test_invert_all();
        test_random();
        test_reset_mid_knight();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
